ad_scheduler: RTL and testbench

AD_SCHEDULER -- requirements
Module: ad_scheduler

---
 rtl/ad_scheduler.sv | 157 +++++++++++++++
 tb/tb_ad_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ad_scheduler.sv
// Ad scheduler: request FIFO, frequency-capped presentation FSM
// and saturating per-ad impression counters.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   req_valid/req_movie upstream ad request (push when req_ready)
//   req_ready           FIFO not full
//   ad_valid/ad_id      ad currently presented to the display
//   ad_ack              display consumed the presented ad
//   count_sel/count_out combinational impression counter readout
//   busy                FIFO non-empty or an ad is being presented
module ad_scheduler #(
    parameter int DEPTH = 4,
    parameter int CAP   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_movie,
    output logic       req_ready,
    output logic       ad_valid,
    output logic [1:0] ad_id,
    input  logic       ad_ack,
    input  logic [1:0] count_sel,
    output logic [7:0] count_out,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t state, state_nx;

    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   occ;
    logic          full, empty;
    logic          push, pop, done;

    logic [1:0]    head, sel_id;
    logic          capped;
    logic [1:0]    last_id;
    logic [1:0]    rep;
    logic [7:0]    cnt [4];

    assign full  = (occ == (AW+1)'(DEPTH));
    assign empty = (occ == '0);

    // A full FIFO refuses a push even when a pop frees a slot
    // in the same cycle.
    assign req_ready = ~full;
    assign push      = req_valid & ~full;

    assign ad_valid = (state == PRESENT);
    assign done     = ad_valid & ad_ack;
    assign busy     = ~empty | ad_valid;

    assign head = mem[rptr];

    // Code 11 is never capped; anything else is replaced by 11
    // once it has been acknowledged CAP times in a row.
    assign capped = (head != 2'b11) && (head == last_id)
                 && ({30'd0, rep} >= 32'(CAP));
    assign sel_id = capped ? 2'b11 : head;

    assign count_out = cnt[count_sel];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    state_nx = PRESENT;
                end
            end
            PRESENT: begin
                if (ad_ack) begin
                    state_nx = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr <= '0;
            rptr <= '0;
            occ  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 2'b00;
            end
        end else begin
            if (push) begin
                mem[wptr] <= req_movie;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ad_id <= 2'b00;
        end else if (pop) begin
            ad_id <= sel_id;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_id <= 2'b00;
            rep     <= 2'd0;
        end else if (done) begin
            if (ad_id == last_id) begin
                if (rep != 2'd3) begin
                    rep <= rep + 2'd1;
                end
            end else begin
                last_id <= ad_id;
                rep     <= 2'd1;
            end
        end
    end

    // Indexed by the presented code, so substitutions count as 11.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= 8'd0;
            end
        end else if (done && cnt[ad_id] != 8'hff) begin
            cnt[ad_id] <= cnt[ad_id] + 8'd1;
        end
    end

endmodule

// File: tb/tb_ad_scheduler.sv
// Directed testbench for ad_scheduler.
// Inputs change and outputs are sampled on the falling edge.
module tb_ad_scheduler;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic [1:0] req_movie;
    logic       req_ready;
    logic       ad_valid;
    logic [1:0] ad_id;
    logic       ad_ack;
    logic [1:0] count_sel;
    logic [7:0] count_out;
    logic       busy;

    int checks;
    int errors;

    ad_scheduler #(.DEPTH(4), .CAP(2)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_movie (req_movie),
        .req_ready (req_ready),
        .ad_valid  (ad_valid),
        .ad_id     (ad_id),
        .ad_ack    (ad_ack),
        .count_sel (count_sel),
        .count_out (count_out),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_reset();
        reset     = 1'b0;
        req_valid = 1'b0;
        req_movie = 2'b00;
        ad_ack    = 1'b0;
        count_sel = 2'b00;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic push1(input logic [1:0] m);
        @(negedge clock);
        req_valid = 1'b1;
        req_movie = m;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic take_ad(output logic [1:0] id, output bit ok);
        ok = 1'b0;
        id = 2'b00;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clock);
            if (ad_valid) begin
                ok = 1'b1;
                id = ad_id;
            end
        end
        if (ok) begin
            ad_ack = 1'b1;
            @(negedge clock);
            ad_ack = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        #1;
        checks++;
        if (ad_valid !== 1'b0 || ad_id !== 2'b00 || req_ready !== 1'b1
            || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%b id=%b ready=%b busy=%b want 0 00 1 0",
                     ad_valid, ad_id, req_ready, busy);
        end
        for (int s = 0; s < 4; s++) begin
            count_sel = 2'(s);
            #1;
            checks++;
            if (count_out !== 8'd0) begin
                errors++;
                $display("FAIL reset_count[%0d]: got %0d want 0", s, count_out);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        ad_ack = 1'b1;
        repeat (2) @(negedge clock);
        count_sel = 2'b00;
        #1;
        checks++;
        if (count_out !== 8'd0 || ad_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: cnt00=%0d valid=%b want 0 0",
                     count_out, ad_valid);
        end
        req_valid = 1'b1;
        req_movie = 2'b01;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (ad_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_e0: valid=%b busy=%b want 0 1", ad_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (ad_valid !== 1'b1 || ad_id !== 2'b01) begin
            errors++;
            $display("FAIL single_e1: valid=%b id=%b want 1 01", ad_valid, ad_id);
        end
        @(negedge clock);
        count_sel = 2'b01;
        #1;
        checks++;
        if (ad_valid !== 1'b0 || busy !== 1'b0 || count_out !== 8'd1) begin
            errors++;
            $display("FAIL single_e2: valid=%b busy=%b cnt01=%0d want 0 0 1",
                     ad_valid, busy, count_out);
        end
        ad_ack = 1'b0;
    endtask

    task automatic test_full();
        logic [1:0] codes [5];
        logic [1:0] expd [5];
        logic [1:0] id;
        bit ok;
        codes = '{2'b01, 2'b10, 2'b11, 2'b01, 2'b10};
        expd  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        do_reset();
        push1(2'b00);
        @(negedge clock);
        checks++;
        if (ad_valid !== 1'b1 || ad_id !== 2'b00) begin
            errors++;
            $display("FAIL full_hold: valid=%b id=%b want 1 00", ad_valid, ad_id);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (req_ready !== (i < 4)) begin
                errors++;
                $display("FAIL full_ready[%0d]: got %b want %b", i, req_ready, i < 4);
            end
            req_valid = 1'b1;
            req_movie = codes[i];
            @(negedge clock);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            take_ad(id, ok);
            checks++;
            if (!ok || id !== expd[i]) begin
                errors++;
                $display("FAIL full_order[%0d]: got %b ok=%b want %b", i, id, ok, expd[i]);
            end
        end
        @(negedge clock);
        checks++;
        if (busy !== 1'b0 || req_ready !== 1'b1 || ad_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drained: busy=%b ready=%b valid=%b want 0 1 0",
                     busy, req_ready, ad_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clock);
        req_valid = 1'b1;
        req_movie = 2'b01;
        @(negedge clock);
        req_movie = 2'b10;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (ad_valid !== 1'b1 || ad_id !== 2'b01 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first: valid=%b id=%b ready=%b want 1 01 1",
                     ad_valid, ad_id, req_ready);
        end
        ad_ack = 1'b1;
        @(negedge clock);
        checks++;
        if (ad_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_bubble: valid=%b busy=%b want 0 1", ad_valid, busy);
        end
        @(negedge clock);
        checks++;
        if (ad_valid !== 1'b1 || ad_id !== 2'b10) begin
            errors++;
            $display("FAIL b2b_second: valid=%b id=%b want 1 10", ad_valid, ad_id);
        end
        @(negedge clock);
        ad_ack = 1'b0;
        count_sel = 2'b10;
        #1;
        checks++;
        if (ad_valid !== 1'b0 || busy !== 1'b0 || count_out !== 8'd1) begin
            errors++;
            $display("FAIL b2b_end: valid=%b busy=%b cnt10=%0d want 0 0 1",
                     ad_valid, busy, count_out);
        end
    endtask

    task automatic test_cap();
        logic [1:0] expd [4];
        logic [1:0] id;
        bit ok;
        expd = '{2'b00, 2'b00, 2'b11, 2'b00};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push1(2'b00);
            take_ad(id, ok);
            checks++;
            if (!ok || id !== expd[i]) begin
                errors++;
                $display("FAIL cap_seq[%0d]: got %b ok=%b want %b", i, id, ok, expd[i]);
            end
        end
        count_sel = 2'b00;
        #1;
        checks++;
        if (count_out !== 8'd3) begin
            errors++;
            $display("FAIL cap_cnt00: got %0d want 3", count_out);
        end
        count_sel = 2'b11;
        #1;
        checks++;
        if (count_out !== 8'd1) begin
            errors++;
            $display("FAIL cap_cnt11: got %0d want 1", count_out);
        end
    endtask

    task automatic test_never_cap();
        logic [1:0] id;
        bit ok;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            push1(2'b11);
            take_ad(id, ok);
            checks++;
            if (!ok || id !== 2'b11) begin
                errors++;
                $display("FAIL nocap_seq[%0d]: got %b ok=%b want 11", i, id, ok);
            end
        end
        count_sel = 2'b11;
        #1;
        checks++;
        if (count_out !== 8'd5) begin
            errors++;
            $display("FAIL nocap_cnt11: got %0d want 5", count_out);
        end
    endtask

    task automatic test_saturate();
        int n;
        bit fin;
        n   = 0;
        fin = 1'b0;
        do_reset();
        ad_ack    = 1'b1;
        req_movie = 2'b10;
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge clock);
            if (n == 400 && !busy) begin
                fin = 1'b1;
            end else if (n < 400) begin
                req_valid = 1'b1;
                if (req_ready) n++;
            end else begin
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
        ad_ack    = 1'b0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL sat_timeout: pushed %0d busy=%b want drained", n, busy);
        end
        count_sel = 2'b10;
        #1;
        checks++;
        if (count_out !== 8'd255) begin
            errors++;
            $display("FAIL sat_cnt10: got %0d want 255", count_out);
        end
        count_sel = 2'b11;
        #1;
        checks++;
        if (count_out !== 8'd133) begin
            errors++;
            $display("FAIL sat_cnt11: got %0d want 133", count_out);
        end
    endtask

    task automatic test_async_reset();
        logic [1:0] id;
        bit ok;
        do_reset();
        push1(2'b00);
        take_ad(id, ok);
        push1(2'b01);
        push1(2'b10);
        push1(2'b11);
        count_sel = 2'b00;
        #1;
        checks++;
        if (ad_valid !== 1'b1 || ad_id !== 2'b01 || count_out !== 8'd1) begin
            errors++;
            $display("FAIL arst_pre: valid=%b id=%b cnt00=%0d want 1 01 1",
                     ad_valid, ad_id, count_out);
        end
        ad_ack = 1'b1;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (ad_valid !== 1'b0 || ad_id !== 2'b00 || busy !== 1'b0
            || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL arst_outputs: valid=%b id=%b busy=%b ready=%b want 0 00 0 1",
                     ad_valid, ad_id, busy, req_ready);
        end
        for (int s = 0; s < 4; s++) begin
            count_sel = 2'(s);
            #1;
            checks++;
            if (count_out !== 8'd0) begin
                errors++;
                $display("FAIL arst_count[%0d]: got %0d want 0", s, count_out);
            end
        end
        ad_ack = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if (ad_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_discard: valid=%b busy=%b want 0 0", ad_valid, busy);
        end
        push1(2'b10);
        take_ad(id, ok);
        checks++;
        if (!ok || id !== 2'b10) begin
            errors++;
            $display("FAIL arst_resume: got %b ok=%b want 10", id, ok);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        req_movie = 2'b00;
        ad_ack    = 1'b0;
        count_sel = 2'b00;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_cap();
        test_never_cap();
        test_saturate();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
